// File: rtl/taillight_seq.sv
// Tail-light sequencing stage: synchronizes the driver switches, holds the light-mode
// register and produces the sweep/blink counters consumed by the output decoder.
module taillight_seq #(
  parameter int TICK_DIV = 12500000,
  parameter int TICK_W   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       brake,
  input  logic       hazard,
  output logic [2:0] current_state,
  output logic [1:0] count_lb,
  output logic [1:0] count_rb,
  output logic       count_h,
  output logic       tick
);

  typedef enum logic [2:0] {
    IDEL   = 3'b000,
    LEFT   = 3'b001,
    RIGHT  = 3'b010,
    LBREAK = 3'b011,
    RBREAK = 3'b100,
    BREAK  = 3'b101,
    HAZARD = 3'b110
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [1:0] FAM_NONE  = 2'b00;
  localparam logic [1:0] FAM_LEFT  = 2'b01;
  localparam logic [1:0] FAM_RIGHT = 2'b10;

  // Switch vectors are packed as {hazard, brake, right, left}.
  logic [3:0]        sync1_r;
  logic [3:0]        sync2_r;
  state_t            state_r;
  state_t            next_state_s;
  logic [TICK_W-1:0] presc_r;
  logic [TICK_W-1:0] presc_next_s;
  logic [1:0]        count_lb_r;
  logic [1:0]        count_rb_r;
  logic              count_h_r;
  logic              tick_r;
  logic              restart_s;
  logic              wrap_s;
  logic              lb_active_s;
  logic              rb_active_s;
  logic              h_active_s;

  function automatic state_t decode_mode(input logic [3:0] sw);
    logic l;
    logic r;
    logic b;
    logic h;
    l = sw[0];
    r = sw[1];
    b = sw[2];
    h = sw[3];
    if (h || (l && r)) begin
      decode_mode = HAZARD;
    end else if (b && l) begin
      decode_mode = LBREAK;
    end else if (b && r) begin
      decode_mode = RBREAK;
    end else if (b) begin
      decode_mode = BREAK;
    end else if (l) begin
      decode_mode = LEFT;
    end else if (r) begin
      decode_mode = RIGHT;
    end else begin
      decode_mode = IDEL;
    end
  endfunction

  // Modes sharing a sweep counter form a family; moving within one keeps the sweep alive.
  function automatic logic [1:0] mode_family(input state_t s);
    case (s)
      LEFT, LBREAK:  mode_family = FAM_LEFT;
      RIGHT, RBREAK: mode_family = FAM_RIGHT;
      default:       mode_family = FAM_NONE;
    endcase
  endfunction

  // Next-state decode, restart detection and prescaler next value.
  always_comb begin
    next_state_s = decode_mode(sync2_r);
    lb_active_s  = (mode_family(next_state_s) == FAM_LEFT);
    rb_active_s  = (mode_family(next_state_s) == FAM_RIGHT);
    h_active_s   = (next_state_s == HAZARD);
    wrap_s       = (presc_r == TICK_LAST);
    if (next_state_s == state_r) begin
      restart_s = 1'b0;
    end else if ((mode_family(next_state_s) != FAM_NONE) &&
                 (mode_family(next_state_s) == mode_family(state_r))) begin
      restart_s = 1'b0;
    end else begin
      restart_s = 1'b1;
    end
    if (restart_s || wrap_s) begin
      presc_next_s = {TICK_W{1'b0}};
    end else begin
      presc_next_s = presc_r + TICK_W'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous driver switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {hazard, brake, right, left};
      sync2_r <= sync1_r;
    end
  end

  // Mode register, prescaler and animation counters; a restart outranks a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDEL;
      presc_r    <= {TICK_W{1'b0}};
      tick_r     <= 1'b0;
      count_lb_r <= 2'b00;
      count_rb_r <= 2'b00;
      count_h_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      presc_r <= presc_next_s;
      tick_r  <= wrap_s && !restart_s;
      if (restart_s) begin
        count_lb_r <= 2'b00;
        count_rb_r <= 2'b00;
        count_h_r  <= 1'b0;
      end else begin
        count_lb_r <= lb_active_s ? (count_lb_r + {1'b0, tick_r}) : 2'b00;
        count_rb_r <= rb_active_s ? (count_rb_r + {1'b0, tick_r}) : 2'b00;
        count_h_r  <= h_active_s ? (count_h_r ^ tick_r) : 1'b0;
      end
    end
  end

  assign current_state = state_r;
  assign count_lb      = count_lb_r;
  assign count_rb      = count_rb_r;
  assign count_h       = count_h_r;
  assign tick          = tick_r;

endmodule

// File: tb/tb_taillight_seq.sv
// Self-checking bench for taillight_seq: decode table, directed corner sequences and
// randomized switch activity against a cycle-level reference model.
module tb_taillight_seq;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       left;
  logic       right;
  logic       brake;
  logic       hazard;
  logic [2:0] current_state;
  logic [1:0] count_lb;
  logic [1:0] count_rb;
  logic       count_h;
  logic       tick;

  taillight_seq #(.TICK_DIV(DIV), .TICK_W(3)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake), .hazard(hazard),
    .current_state(current_state), .count_lb(count_lb), .count_rb(count_rb),
    .count_h(count_h), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: switch history plus "edges since the prescaler last restarted".
  logic [3:0] h1 = 4'd0;
  logic [3:0] h2 = 4'd0;
  int m_mode = 0, m_lb = 0, m_rb = 0, m_h = 0, m_age = 0;

  function automatic int decode(input logic [3:0] v);
    int l, r, b, h;
    l = v[0]; r = v[1]; b = v[2]; h = v[3];
    if (h == 1 || (l == 1 && r == 1)) return 6;
    if (b == 1) return (l == 1) ? 3 : (r == 1) ? 4 : 5;
    return (l == 1) ? 1 : (r == 1) ? 2 : 0;
  endfunction

  function automatic int family(input int m);
    if (m == 1 || m == 3) return 1;
    if (m == 2 || m == 4) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int nxt, tb;
    if (reset) begin
      h1 = 4'd0; h2 = 4'd0;
      m_mode = 0; m_lb = 0; m_rb = 0; m_h = 0; m_age = 0;
    end else begin
      nxt = decode(h2);
      tb  = (m_age > 0 && m_age % DIV == 0) ? 1 : 0;
      if (nxt == m_mode || (family(nxt) != 0 && family(nxt) == family(m_mode))) begin
        m_age++;
        m_lb = (family(nxt) == 1) ? (m_lb + tb) % 4 : 0;
        m_rb = (family(nxt) == 2) ? (m_rb + tb) % 4 : 0;
        m_h  = (nxt == 6) ? (m_h ^ tb) : 0;
      end else begin
        m_age = 0; m_lb = 0; m_rb = 0; m_h = 0;
      end
      m_mode = nxt;
      h2 = h1;
      h1 = {hazard, brake, right, left};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_state", int'(current_state), m_mode);
    chk("model_count_lb", int'(count_lb), m_lb);
    chk("model_count_rb", int'(count_rb), m_rb);
    chk("model_count_h", int'(count_h), m_h);
    chk("model_tick", int'(tick), (m_age > 0 && m_age % DIV == 0) ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sw(input logic l, input logic r, input logic b, input logic h);
    left = l; right = r; brake = b; hazard = h;
  endtask

  task automatic reset_with(input logic l, input logic r, input logic b, input logic h);
    reset = 1'b1;
    set_sw(l, r, b, h);
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       l;
    logic       r;
    logic       b;
    logic       h;
    logic [2:0] exp_state;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b1;
    set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b011};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b101};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b110};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b110};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b110};

    // Reset held 3 cycles with every switch high, then release.
    set_sw(1'b1, 1'b1, 1'b1, 1'b1);
    run(3);
    chk("rst_state", int'(current_state), 0);
    chk("rst_counts", int'({count_lb, count_rb, count_h}), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b0;
    run(2);
    chk("rst_release_latency", int'(current_state), 0);
    run(1);
    chk("rst_release_hazard", int'(current_state), 6);

    // Decode table.
    for (int i = 0; i < 10; i++) begin
      reset_with(tbl[i].l, tbl[i].r, tbl[i].b, tbl[i].h);
      run(3);
      chk("vec_state", int'(current_state), int'(tbl[i].exp_state));
      chk("vec_counts", int'({count_lb, count_rb, count_h}), 0);
    end

    // Left sweep, then brake mid-sweep (continues), then release left.
    reset_with(1'b0, 1'b0, 1'b0, 1'b0);
    left = 1'b1;
    run(7);
    chk("sweep_lb_e7", int'(count_lb), 0);
    chk("sweep_tick_e7", int'(tick), 1);
    run(1);
    chk("sweep_lb_e8", int'(count_lb), 1);
    run(4);
    chk("sweep_lb_e12", int'(count_lb), 2);
    chk("sweep_other", int'({count_rb, count_h}), 0);
    run(1);
    brake = 1'b1;
    run(3);
    chk("lbrake_state", int'(current_state), 3);
    chk("lbrake_lb_continues", int'(count_lb), 3);
    left = 1'b0;
    run(3);
    chk("brake_state", int'(current_state), 5);
    chk("brake_counts", int'({count_lb, count_rb, count_h}), 0);

    // Hazard override during a right sweep, then mid-operation reset.
    reset_with(1'b0, 1'b0, 1'b0, 1'b0);
    right = 1'b1;
    run(8);
    chk("right_rb_e8", int'(count_rb), 1);
    hazard = 1'b1;
    run(3);
    chk("haz_state", int'(current_state), 6);
    chk("haz_rb_clear", int'(count_rb), 0);
    run(5);
    chk("haz_h_e16", int'(count_h), 1);
    run(4);
    chk("haz_h_e20", int'(count_h), 0);
    run(4);
    chk("haz_h_e24", int'(count_h), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_state", int'(current_state), 0);
    chk("midrst_h", int'(count_h), 0);
    chk("midrst_tick", int'(tick), 0);
    run(3);
    chk("midrst_haz_back", int'(current_state), 6);
    run(4);
    chk("midrst_tick_e32", int'(tick), 1);
    chk("midrst_h_e32", int'(count_h), 0);
    run(1);
    chk("midrst_h_e33", int'(count_h), 1);
    set_sw(1'b1, 1'b1, 1'b0, 1'b0);
    run(4);
    chk("lr_hazard", int'(current_state), 6);

    // State change landing on a tick: no increment, fresh prescaler.
    reset_with(1'b0, 1'b0, 1'b0, 1'b0);
    left = 1'b1;
    run(9);
    set_sw(1'b0, 1'b1, 1'b0, 1'b0);
    run(3);
    chk("coin_state", int'(current_state), 2);
    chk("coin_lb", int'(count_lb), 0);
    chk("coin_rb", int'(count_rb), 0);
    chk("coin_tick", int'(tick), 0);
    run(3);
    chk("coin_tick_e15", int'(tick), 0);
    run(1);
    chk("coin_tick_e16", int'(tick), 1);
    run(1);
    chk("coin_rb_e17", int'(count_rb), 1);

    // Randomized switch activity with occasional resets.
    reset_with(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        {brake, right, left} = 3'($urandom_range(0, 7));
        hazard = ($urandom_range(0, 3) == 0);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
